// File: rtl/key_schedule.sv
// AES-128 round-key generator: loads a cipher key and streams round keys 0..10,
// computing each next key on the fly from the current one under a valid/ready handshake.
module key_schedule #(
  parameter int NR = 10
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic [127:0] key_i,
  input  logic         rk_ready_i,
  output logic [127:0] rk_o,
  output logic [3:0]   rk_idx_o,
  output logic         rk_valid_o,
  output logic         busy_o,
  output logic         done_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FINISH = 2'd2
  } state_t;

  // AES S-box, entry 0x00 in the most significant byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    logic [10:0] pos;
    pos = 11'd2047 - {b, 3'b000};
    return SBOX[pos -: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sub_byte(w[31:24]), sub_byte(w[23:16]), sub_byte(w[15:8]), sub_byte(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  state_t         state_r, state_nx;
  logic [127:0]   key_r;
  logic [3:0]     idx_r;
  logic           stream_r;
  logic           done_r;
  logic           handshake_s;
  logic           last_s;
  logic [31:0]    t_s, n0_s, n1_s, n2_s, n3_s;
  logic [127:0]   next_key_s;

  assign handshake_s = (state_r == STREAM) && rk_ready_i;
  assign last_s      = (idx_r == 4'(NR));

  // Next round key: rotate/substitute the last word, add Rcon, then ripple the XOR chain.
  always_comb begin
    t_s        = sub_word({key_r[23:0], key_r[31:24]}) ^ {rcon(idx_r + 4'd1), 24'h000000};
    n0_s       = key_r[127:96] ^ t_s;
    n1_s       = key_r[95:64]  ^ n0_s;
    n2_s       = key_r[63:32]  ^ n1_s;
    n3_s       = key_r[31:0]   ^ n2_s;
    next_key_s = {n0_s, n1_s, n2_s, n3_s};
  end

  // Next-state decode.
  always_comb begin
    state_nx = state_r;
    case (state_r)
      IDLE:    if (start_i) state_nx = STREAM; else state_nx = IDLE;
      STREAM:  if (handshake_s && last_s) state_nx = FINISH; else state_nx = STREAM;
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_r <= IDLE;
    else       state_r <= state_nx;
  end

  // Key/index datapath and registered status flags; the key register reads as zero outside STREAM.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      key_r    <= 128'd0;
      idx_r    <= 4'd0;
      stream_r <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      stream_r <= (state_nx == STREAM);
      done_r   <= (state_nx == FINISH);
      case (state_r)
        IDLE: begin
          idx_r <= 4'd0;
          if (start_i) key_r <= key_i;
          else         key_r <= 128'd0;
        end
        STREAM: begin
          if (handshake_s && !last_s) begin
            key_r <= next_key_s;
            idx_r <= idx_r + 4'd1;
          end else if (handshake_s) begin
            key_r <= 128'd0;
            idx_r <= 4'd0;
          end else begin
            key_r <= key_r;
            idx_r <= idx_r;
          end
        end
        FINISH: begin
          key_r <= 128'd0;
          idx_r <= 4'd0;
        end
        default: begin
          key_r <= 128'd0;
          idx_r <= 4'd0;
        end
      endcase
    end
  end

  assign rk_o       = key_r;
  assign rk_idx_o   = idx_r;
  assign rk_valid_o = stream_r;
  assign busy_o     = stream_r;
  assign done_o     = done_r;

endmodule

// File: tb/tb_key_schedule.sv
// Directed bench for key_schedule: FIPS-197 key expansion vectors, stalls, ignored
// restarts, mid-sequence reset, zero key and back-to-back sequences.
module tb_key_schedule;

  logic         clk = 1'b0;
  logic         rst, start, ready;
  logic [127:0] key;
  logic [127:0] rk;
  logic [3:0]   rk_idx;
  logic         rk_valid, busy, done;

  int vectors = 0;
  int miscompares = 0;

  logic [127:0] exp_k [0:10];
  localparam logic [127:0] K1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K2   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K2_1 = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
  localparam logic [127:0] Z_1  = 128'h62636363626363636263636362636363;

  key_schedule #(.NR(10)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .key_i(key), .rk_ready_i(ready),
    .rk_o(rk), .rk_idx_o(rk_idx), .rk_valid_o(rk_valid), .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_rk"}, rk, 128'd0);
    check({tag, "_idx"}, 128'(rk_idx), 128'd0);
    check({tag, "_valid"}, 128'(rk_valid), 128'd0);
    check({tag, "_busy"}, 128'(busy), 128'd0);
    check({tag, "_done"}, 128'(done), 128'd0);
  endtask

  logic         prev_stall;
  logic [127:0] prev_rk;
  logic [3:0]   prev_idx;
  int           hs_cnt, done_cnt;

  initial begin
    exp_k[0]  = K1;
    exp_k[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    exp_k[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    exp_k[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    exp_k[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    exp_k[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    exp_k[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    exp_k[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    exp_k[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    exp_k[9]  = 128'hac7766f319fadc2128d12941575c006e;
    exp_k[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    rst = 1'b1; start = 1'b0; ready = 1'b0; key = 128'd0;
    step; step;
    check_idle("reset");
    rst = 1'b0;
    step;

    // Full sequence with ready held high; start accepted at edge T.
    key = K1; start = 1'b1; ready = 1'b1;
    step;
    start = 1'b0;
    for (int k = 0; k <= 10; k++) begin
      check($sformatf("s1_rk%0d", k), rk, exp_k[k]);
      check($sformatf("s1_idx%0d", k), 128'(rk_idx), 128'(k));
      check($sformatf("s1_valid%0d", k), 128'(rk_valid), 128'd1);
      check($sformatf("s1_busy%0d", k), 128'(busy), 128'd1);
      check($sformatf("s1_done%0d", k), 128'(done), 128'd0);
      step;
    end
    check("s1_done_pulse", 128'(done), 128'd1);
    check("s1_fin_valid", 128'(rk_valid), 128'd0);
    check("s1_fin_busy", 128'(busy), 128'd0);
    check("s1_fin_rk", rk, 128'd0);
    step;
    check_idle("s1_after");

    // Random back-pressure with stray start pulses carrying another key.
    key = K1; start = 1'b1; ready = 1'b0;
    step;
    start = 1'b0;
    prev_stall = 1'b0; hs_cnt = 0; done_cnt = 0;
    for (int c = 0; c < 150; c++) begin
      if (prev_stall) begin
        check("s2_stall_rk", rk, prev_rk);
        check("s2_stall_idx", 128'(rk_idx), 128'(prev_idx));
      end
      if (rk_valid) check("s2_rk", rk, (rk_idx <= 4'd10) ? exp_k[rk_idx] : 128'd0);
      if (done) done_cnt++;
      ready = 1'($urandom_range(0, 1));
      start = rk_valid && (rk_idx < 4'd8) && ($urandom_range(0, 3) == 0);
      key = K2;
      if (rk_valid && ready) hs_cnt++;
      prev_stall = rk_valid && !ready;
      prev_rk = rk;
      prev_idx = rk_idx;
      step;
    end
    start = 1'b0;
    check("s2_handshakes", 128'(hs_cnt), 128'd11);
    check("s2_done_count", 128'(done_cnt), 128'd1);
    check_idle("s2_after");

    // Reset while round key 5 is presented.
    key = K1; start = 1'b1; ready = 1'b1;
    step;
    start = 1'b0;
    for (int k = 0; k < 5; k++) step;
    check("s3_idx5", 128'(rk_idx), 128'd5);
    check("s3_rk5", rk, exp_k[5]);
    rst = 1'b1;
    step;
    rst = 1'b0;
    check_idle("s3_reset");
    for (int k = 0; k < 3; k++) begin
      step;
      check($sformatf("s3_nodone%0d", k), 128'(done), 128'd0);
      check($sformatf("s3_novalid%0d", k), 128'(rk_valid), 128'd0);
    end
    key = K2; start = 1'b1;
    step;
    start = 1'b0;
    check("s3_new_rk0", rk, K2);
    check("s3_new_idx0", 128'(rk_idx), 128'd0);
    step;
    check("s3_new_rk1", rk, K2_1);
    for (int k = 0; k < 11; k++) step;

    // All-zero key.
    key = 128'd0; start = 1'b1;
    step;
    start = 1'b0;
    check("s4_valid0", 128'(rk_valid), 128'd1);
    check("s4_rk0", rk, 128'd0);
    step;
    check("s4_rk1", rk, Z_1);
    check("s4_idx1", 128'(rk_idx), 128'd1);
    for (int k = 0; k < 11; k++) step;
    check_idle("s4_after");

    // start held high continuously: second sequence follows the one-cycle IDLE.
    key = K1; start = 1'b1; ready = 1'b1;
    step;
    for (int k = 0; k <= 10; k++) begin
      check($sformatf("s5_rk%0d", k), rk, exp_k[k]);
      if (k == 4) key = K2;
      step;
    end
    check("s5_done", 128'(done), 128'd1);
    check("s5_fin_valid", 128'(rk_valid), 128'd0);
    step;
    check("s5_idle_valid", 128'(rk_valid), 128'd0);
    check("s5_idle_done", 128'(done), 128'd0);
    step;
    check("s5_second_valid", 128'(rk_valid), 128'd1);
    check("s5_second_idx", 128'(rk_idx), 128'd0);
    check("s5_second_rk0", rk, K2);
    start = 1'b0;
    step;
    check("s5_second_rk1", rk, K2_1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
